// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and LSU state type for lsu_misalign_rv32i.
package rv32i_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_HI   = 2'd1,
    STORE_SEQ = 2'd2
  } lsu_state_t;

  function automatic logic ld_misaligned(input logic [2:0] lt, input logic [1:0] off);
    case (lt)
      LT_LH, LT_LHU: return off[0];
      LT_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic st_misaligned(input logic [1:0] stt, input logic [1:0] off);
    case (stt)
      ST_SH:   return off[0];
      ST_SW:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract_rv32i.sv
// Byte/halfword lane select plus sign/zero extension of a 32-bit memory word.
module load_extract_rv32i
  import rv32i_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadtype,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (loadtype)
      LT_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      LT_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      LT_LW:   data = shifted;
      LT_LBU:  data = {24'b0, shifted[7:0]};
      LT_LHU:  data = {16'b0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_misalign_rv32i.sv
// RV32I load/store unit; misaligned accesses are split into aligned memory
// operations when LSU_MISALIGN_SPLIT_EN is defined, otherwise flagged on misalign_err.
module lsu_misalign_rv32i
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cu_load,
  input  logic              cu_store,
  input  logic [2:0]        cu_loadtype,
  input  logic [1:0]        cu_storetype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rs2,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misalign_err,
  output logic              mem_store,
  output logic [1:0]        mem_storetype,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic        is_ld;
  logic        is_st;
  logic        mis;
  logic [31:0] ext_word;
  logic [1:0]  ext_off;
  logic [31:0] ext_data;

  // A simultaneous load and store is handled as a store.
  assign is_st = cu_store;
  assign is_ld = cu_load & ~cu_store;
  assign mis   = (is_st & st_misaligned(cu_storetype, addr[1:0])) |
                 (is_ld & ld_misaligned(cu_loadtype, addr[1:0]));

  load_extract_rv32i u_extract (
    .word     (ext_word),
    .offset   (ext_off),
    .loadtype (cu_loadtype),
    .data     (ext_data)
  );

`ifdef LSU_MISALIGN_SPLIT_EN

  lsu_state_t        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       lo_word_q, lo_word_d;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       merged;
  logic [7:0]        st_byte;
  logic              last;
  logic              mem_store_c;
  logic              stall_c;

  assign word_addr = {addr[ADDR_W-1:2], 2'b00};
  assign merged    = 32'({mem_rdata, lo_word_q} >> {addr[1:0], 3'b000});
  assign st_byte   = rs2[{cnt_q, 3'b000} +: 8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      lo_word_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lo_word_q <= lo_word_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lo_word_d     = lo_word_q;
    mem_store_c   = is_st;
    mem_storetype = cu_storetype;
    mem_addr      = addr;
    mem_wdata     = rs2;
    stall_c       = 1'b0;
    ext_word      = mem_rdata;
    ext_off       = addr[1:0];
    last          = 1'b0;
    case (state_q)
      IDLE: begin
        if (mis && is_ld) begin
          mem_addr  = word_addr;
          stall_c   = 1'b1;
          lo_word_d = mem_rdata;
          state_d   = LOAD_HI;
        end else if (mis && is_st) begin
          mem_storetype = ST_SB;
          mem_wdata     = {4{rs2[7:0]}};
          stall_c       = 1'b1;
          cnt_d         = 2'd1;
          state_d       = STORE_SEQ;
        end
      end
      LOAD_HI: begin
        mem_store_c = 1'b0;
        mem_addr    = word_addr + ADDR_W'(4);
        ext_word    = merged;
        ext_off     = 2'b00;
        state_d     = IDLE;
      end
      STORE_SEQ: begin
        // Byte replicated across all lanes so the memory sees it in the addressed lane.
        mem_store_c   = 1'b1;
        mem_storetype = ST_SB;
        mem_addr      = addr + ADDR_W'(cnt_q);
        mem_wdata     = {4{st_byte}};
        last          = (cu_storetype == ST_SH) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);
        stall_c       = ~last;
        if (last) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_store    = mem_store_c & reset_n;
  assign stall        = stall_c & reset_n;
  assign misalign_err = 1'b0;
  assign load_data    = is_st ? 32'd0 : ext_data;

`else

  assign ext_word      = mem_rdata;
  assign ext_off       = addr[1:0];
  assign mem_storetype = cu_storetype;
  assign mem_addr      = addr;
  assign mem_wdata     = rs2;
  assign mem_store     = is_st & ~mis & reset_n;
  assign stall         = 1'b0;
  assign misalign_err  = mis & reset_n;
  assign load_data     = (is_st | mis) ? 32'd0 : ext_data;

`endif

endmodule

// File: doc/lsu_misalign_rv32i.md
# lsu_misalign_rv32i

Load/store unit between the RV32I single-cycle datapath and the data memory. Aligned accesses pass through in one cycle. Misaligned accesses are split into a short sequence of aligned memory operations while the core is stalled. The block also performs load byte-lane selection and sign/zero extension, so the core always receives a final 32-bit `rd` value.

## Interface

Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cu_load`, in, 1: load instruction this cycle.
- `cu_store`, in, 1: store instruction this cycle.
- `cu_loadtype`, in, 3: funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `cu_storetype`, in, 2: 00 SB, 01 SH, 10 SW.
- `addr`, in, ADDR_W: byte address from the ALU.
- `rs2`, in, 32: store data.
- `load_data`, out, 32: extended load result, combinational.
- `stall`, out, 1: core must hold PC and all inputs stable.
- `misalign_err`, out, 1: misaligned access rejected. Only when the split feature is compiled out.
- `mem_store`, out, 1: memory write enable.
- `mem_storetype`, out, 2: storetype presented to memory.
- `mem_addr`, out, ADDR_W: byte address presented to memory.
- `mem_wdata`, out, 32: write data presented to memory.
- `mem_rdata`, in, 32: asynchronous word read data from memory.

## Operation

Alignment:
- An access is misaligned when LH/LHU/SH has `addr[0]`=1, or LW/SW has `addr[1:0]`≠0.
- LB, LBU and SB are always aligned.

Aligned access (state IDLE):
- Memory outputs are a pass-through of the core inputs.
- `stall`=0.
- `load_data` = extract(`mem_rdata`, `addr[1:0]`, loadtype).

Misaligned load, FSM IDLE→LOAD_HI→IDLE:
- Cycle 0: `mem_addr`=`addr`&~3, `stall`=1; `mem_rdata` is latched into `lo_word` at the clock edge.
- Cycle 1: `mem_addr`=(`addr`&~3)+4, `stall`=0.
- `load_data` is taken from the 64-bit concatenation {`mem_rdata`,`lo_word`} >> (8·`addr[1:0]`), then extended per loadtype.

Misaligned store, FSM IDLE→STORE_SEQ→IDLE:
- Issued as N byte stores, N=2 for SH and N=4 for SW.
- Cycle k (k=0..N-1): `mem_storetype`=SB, `mem_addr`=`addr`+k, `mem_wdata`=`rs2` byte k placed in the lane. `mem_store`=1.
- A 2-bit counter `cnt` tracks k.
- `stall`=1 for cycles 0..N-2 and 0 in cycle N-1.

Extension:
- LB/LH sign-extend from bit 7/15.
- LBU/LHU zero-extend.
- LW is unmodified.
- Other loadtype codes: `load_data`=0.

Other rules:
- `cu_load` and `cu_store` both high: treated as a store; `load_data`=0.
- Neither high: `mem_store`=0, `load_data`=extract of aligned word, no state change.
- Address arithmetic wraps modulo 2^ADDR_W; word+4 past the top wraps to 0.

## Timing

- Memory writes commit on the rising edge when `mem_store`=1. Read is combinational in the same cycle.
- Latency:
  - aligned: 1 cycle, stall 0.
  - misaligned load: 2 cycles, stall 1 cycle.
  - misaligned SH: 2 cycles, stall 1 cycle.
  - misaligned SW: 4 cycles, stall 3 cycles.
- `stall` is combinational from the state plus the current-cycle decode.
- The core samples `load_data` in the cycle where `stall`=0.
- Reset values: state IDLE, `cnt`=0, `lo_word`=0, `misalign_err`=0, `stall`=0. Memory outputs are then a pass-through of the core inputs.
- Reset asserted mid-sequence:
  - immediately returns to IDLE and drops `stall`.
  - byte writes already committed stay in memory.
  - no further writes are issued.

## Configuration

- `LSU_MISALIGN_SPLIT_EN` defined:
  - behaviour as above.
  - `misalign_err` tied to 0.
- Not defined:
  - FSM, `cnt` and `lo_word` are removed.
  - a misaligned access asserts `misalign_err`=1 combinationally for that cycle.
  - `mem_store` is forced to 0, `load_data`=0, `stall`=0.
  - aligned behaviour is unchanged.

## Structure

- Shared package `rv32i_pkg` holds:
  - loadtype and storetype encodings.
  - the `lsu_state_t` enum (IDLE, LOAD_HI, STORE_SEQ).
- Sub-module `load_extract_rv32i`:
  - combinational byte/halfword select plus sign/zero extension.
  - inputs: 32-bit word, 2-bit offset, loadtype.
  - used on both the aligned and the merged path.

## Test plan

Preload memory: word 0x100=0x44332211, word 0x104=0x88776655.
- LW at 0x100 → `stall` never asserted, `load_data`=0x44332211 in cycle 0.
- LW at 0x102 → `stall`=1 for one cycle, then `load_data`=0x66554433. LH at 0x103 → 0x00005544.
- LB at 0x107 → 0xFFFFFF88. LBU at 0x107 → 0x00000088. LHU at 0x106 → 0x00008877.
- SW 0xDEADBEEF at 0x101 → 4 SB writes, `stall` high 3 cycles. Afterwards word 0x100=0xADBEEF11 and word 0x104=0x887766DE.
- Same SW, `reset_n` pulled low after 2 byte writes → `stall` drops immediately. Word 0x100=0x44BEEF11; word 0x104 is unchanged.
- Build without `LSU_MISALIGN_SPLIT_EN`, SH at 0x101 → `misalign_err`=1, `mem_store`=0, memory unchanged.
